eth_rx_led_capture: RTL and testbench
=====================================

# eth_rx_led_capture

Parametrised MII receive monitor in the `eth_rx_clk` domain. It locks onto preamble/SFD, assembles nibbles into bytes, and counts frame length. It captures the byte at a configurable offset after SFD and drives its low bits onto the board LEDs, with a stretched activity indicator. It replaces the fixed 4-LED nibble display and sits between the MII pins and the LED outputs in the board top level.

## Interface
- `LED_W`, 4: LED count, 1..8; LEDs show `capture[LED_W-1:0]`.
- `CAPTURE_OFFSET`, 0: byte index after SFD to capture, 0..2046. Byte 0 is the first destination-MAC byte.
- `HOLD_CYCLES`, 25_000_000: `act` stretch length in `eth_rx_clk` cycles, ≥1.

Ports:
- `eth_rx_clk` in 1: MII receive clock, 25 MHz; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `eth_rx_dv` in 1: MII data valid.
- `eth_rxd` in 4: MII data nibble.
- `eth_rxerr` in 1: MII receive error.
- `led` out LED_W: displayed captured bits.
- `act` out 1: high for HOLD_CYCLES after each frame end.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_len` out 11: byte count of last frame, excluding preamble/SFD; saturates at 2047.
- `frame_cnt` out 16: frames completed; wraps.
- `err_cnt` out 16: frames with rxerr; saturates at 0xFFFF.

## Operation
- FSM states: WAIT, IDLE, PRE, DATA.
  - Reset state is WAIT.
  - WAIT: stay until `eth_rx_dv`=0, then go to IDLE. This prevents locking onto a frame already in progress when reset is released.
  - IDLE: on dv=1 with rxd=0x5, go to PRE. On dv=1 with any other nibble, go to WAIT.
  - PRE: dv=0 goes to IDLE (no frame counted). rxd=0x5 stays. rxd=0xD goes to DATA and clears nibble phase and `byte_cnt`. Any other nibble goes to WAIT.
  - DATA: dv=0 ends the frame and goes to IDLE.
- Byte assembly: MII order is low nibble first. Phase 0 latches `lo`. Phase 1 forms `{rxd, lo}` and increments `byte_cnt`, saturating at 2047.
- Dribble: a trailing odd nibble at frame end is discarded and not counted.
- Capture: when a byte completes with `byte_cnt`=CAPTURE_OFFSET, it is stored in a shadow register and `hit` is set.
- Frame end (DATA and dv=0):
  - `frame_done` pulses.
  - `frame_len`←`byte_cnt`.
  - `frame_cnt`+1.
  - `act` hold counter reloads to HOLD_CYCLES.
  - If `hit` is set and the frame is good, the shadow is committed to the display register.
  - `hit` is cleared.
- Short frame (never reached the offset): counted normally; `led` unchanged.
- Hold counter: decrements to 0. `act` = (counter≠0). A retrigger while nonzero reloads it to full.

## Timing
- Reset values:
  - `led`=0, `act`=0, `frame_done`=0, `frame_len`=0.
  - `frame_cnt`=0, `err_cnt`=0, state=WAIT, hold counter=0.
- All outputs are registered.
- `frame_done`, `frame_len`, `frame_cnt` and `led` update together on the edge that samples dv=0 in DATA. They are visible in the following cycle.
- `act` rises in the same cycle as `frame_done`. It stays high exactly HOLD_CYCLES cycles unless retriggered.
- Back-to-back frames: a dv=0 gap of one cycle is sufficient; IDLE accepts 0x5 on the next cycle.
- Reset mid-frame: all state returns to reset values. No partial frame is counted. The FSM re-syncs through WAIT.

## Configuration
- Macro: `ETH_RX_LED_CAPTURE_ERR_EN`.
- Defined:
  - `eth_rxerr` high in any DATA cycle marks the frame bad.
  - A bad frame still pulses `frame_done` and updates `frame_len`/`frame_cnt`.
  - A bad frame does not commit the capture.
  - A bad frame increments `err_cnt`.
- Undefined:
  - `eth_rxerr` is ignored.
  - Every frame is good.
  - `err_cnt` is tied to 0.

## Structure
- Package `eth_rx_pkg`:
  - State enum (WAIT/IDLE/PRE/DATA).
  - Constants `PREAMBLE_NIB`=4'h5, `SFD_NIB`=4'hD, `BYTE_CNT_W`=11, `CNT_W`=16.
- Sub-module `eth_hold_stretch`:
  - Parameter HOLD_CYCLES.
  - Inputs `eth_rx_clk`, `rst`, `trig`; output `act`.
  - Counter width `$clog2(HOLD_CYCLES+1)`.

## Test plan
- Preamble 15×0x5, 0xD, then 64 bytes with byte 0=0xA7 (CAPTURE_OFFSET=0, LED_W=4):
  - `frame_done` pulses once.
  - `frame_len`=64, `frame_cnt`=1, `led`=4'h7, `act` high for HOLD_CYCLES.
- CAPTURE_OFFSET=20, 10-byte frame: `frame_len`=10, `frame_cnt`=1, `led` keeps its previous value.
- Frame of 5 bytes plus one dribble nibble: `frame_len`=5; capture unaffected by the dribble nibble.
- Reset asserted mid-DATA while dv stays high for 30 more cycles:
  - No `frame_done`.
  - Counters stay 0.
  - The next clean frame is captured correctly.
- Nibble 0x3 in preamble: FSM goes to WAIT, no frame counted. A following valid frame is counted.
- With `ETH_RX_LED_CAPTURE_ERR_EN`, `eth_rxerr` pulsed at byte 12 of a frame with byte 0=0x5C:
  - `err_cnt`=1, `frame_cnt`=1.
  - `led` unchanged.
  - Without the macro: `led`=4'hC and `err_cnt`=0.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive monitor.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        WAIT,
        IDLE,
        PRE,
        DATA
    } rx_state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;
    localparam int         BYTE_CNT_W   = 11;
    localparam int         CNT_W        = 16;

endpackage

// File: rtl/eth_hold_stretch.sv
// Retriggerable pulse stretcher: act stays high for HOLD_CYCLES cycles after the last trig.
module eth_hold_stretch #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic eth_rx_clk,
    input  logic rst,
    input  logic trig,
    output logic act
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt;

    // act is registered alongside the counter so it falls on the edge cnt reaches 0
    always_ff @(posedge eth_rx_clk) begin
        if (rst) begin
            cnt <= '0;
            act <= 1'b0;
        end else if (trig) begin
            cnt <= CW'(HOLD_CYCLES);
            act <= 1'b1;
        end else begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            act <= (cnt > CW'(1));
        end
    end

endmodule

// File: rtl/eth_rx_led_capture.sv
// MII receive monitor: locks to preamble/SFD, counts frame bytes, captures one byte onto the LEDs.
// Optional receive-error tracking is enabled by defining ETH_RX_LED_CAPTURE_ERR_EN.
import eth_rx_pkg::*;

module eth_rx_led_capture #(
    parameter int unsigned LED_W          = 4,
    parameter int unsigned CAPTURE_OFFSET = 0,
    parameter int unsigned HOLD_CYCLES    = 25_000_000
) (
    input  logic                  eth_rx_clk,
    input  logic                  rst,
    input  logic                  eth_rx_dv,
    input  logic [3:0]            eth_rxd,
    input  logic                  eth_rxerr,
    output logic [LED_W-1:0]      led,
    output logic                  act,
    output logic                  frame_done,
    output logic [BYTE_CNT_W-1:0] frame_len,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    rx_state_t state, state_nxt;

    logic                  phase;
    logic [3:0]            lo;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [LED_W-1:0]      shadow;
    logic                  hit;
    logic                  bad;
    logic                  rxerr_seen;
    logic [7:0]            rx_byte;
    logic                  sof;
    logic                  eof;
    logic                  frame_bad;
    logic                  unused_byte_bits;

`ifdef ETH_RX_LED_CAPTURE_ERR_EN
    assign rxerr_seen = eth_rxerr;
`else
    logic unused_rxerr;
    assign unused_rxerr = eth_rxerr;
    assign rxerr_seen   = 1'b0;
`endif

    assign rx_byte          = {eth_rxd, lo};
    assign unused_byte_bits = ^rx_byte;
    assign sof              = (state == PRE) && eth_rx_dv && (eth_rxd == SFD_NIB);
    assign eof              = (state == DATA) && !eth_rx_dv;
    assign frame_bad        = bad | rxerr_seen;

    always_ff @(posedge eth_rx_clk) begin
        if (rst) state <= WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT: if (!eth_rx_dv) state_nxt = IDLE;
            IDLE: if (eth_rx_dv) state_nxt = (eth_rxd == PREAMBLE_NIB) ? PRE : WAIT;
            PRE: begin
                if (!eth_rx_dv)                 state_nxt = IDLE;
                else if (eth_rxd == SFD_NIB)    state_nxt = DATA;
                else if (eth_rxd != PREAMBLE_NIB) state_nxt = WAIT;
            end
            DATA: if (!eth_rx_dv) state_nxt = IDLE;
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge eth_rx_clk) begin
        if (rst) begin
            phase      <= 1'b0;
            lo         <= '0;
            byte_cnt   <= '0;
            shadow     <= '0;
            hit        <= 1'b0;
            bad        <= 1'b0;
            led        <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (sof) begin
                phase    <= 1'b0;
                byte_cnt <= '0;
                hit      <= 1'b0;
                bad      <= 1'b0;
            end else if ((state == DATA) && eth_rx_dv) begin
                if (rxerr_seen) bad <= 1'b1;
                if (!phase) begin
                    lo    <= eth_rxd;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (byte_cnt != '1) byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    if (byte_cnt == BYTE_CNT_W'(CAPTURE_OFFSET)) begin
                        shadow <= rx_byte[LED_W-1:0];
                        hit    <= 1'b1;
                    end
                end
            end else if (eof) begin
                // a pending odd nibble is simply dropped by clearing phase
                frame_done <= 1'b1;
                frame_len  <= byte_cnt;
                frame_cnt  <= frame_cnt + CNT_W'(1);
                if (hit && !frame_bad) led <= shadow;
                if (frame_bad && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
                hit        <= 1'b0;
                bad        <= 1'b0;
                phase      <= 1'b0;
            end
        end
    end

    eth_hold_stretch #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .eth_rx_clk(eth_rx_clk),
        .rst       (rst),
        .trig      (eof),
        .act       (act)
    );

endmodule

// File: tb/tb_eth_rx_led_capture.sv
// Self-checking bench for eth_rx_led_capture: directed table, hand sequences, randomized frames vs. model.
module tb_eth_rx_led_capture;

    localparam int HOLD = 20;
    localparam int OFF2 = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dv  = 1'b0;
    logic err = 1'b0;
    logic [3:0] rxd = 4'h0;

    logic [3:0]  led0, led20;
    logic        act0, act20, done0, done20;
    logic [10:0] len0, len20;
    logic [15:0] cnt0, cnt20, ecnt0, ecnt20;

    eth_rx_led_capture #(.LED_W(4), .CAPTURE_OFFSET(0), .HOLD_CYCLES(HOLD)) dut0 (
        .eth_rx_clk(clk), .rst(rst), .eth_rx_dv(dv), .eth_rxd(rxd), .eth_rxerr(err),
        .led(led0), .act(act0), .frame_done(done0), .frame_len(len0),
        .frame_cnt(cnt0), .err_cnt(ecnt0)
    );

    eth_rx_led_capture #(.LED_W(4), .CAPTURE_OFFSET(OFF2), .HOLD_CYCLES(HOLD)) dut20 (
        .eth_rx_clk(clk), .rst(rst), .eth_rx_dv(dv), .eth_rxd(rxd), .eth_rxerr(err),
        .led(led20), .act(act20), .frame_done(done20), .frame_len(len20),
        .frame_cnt(cnt20), .err_cnt(ecnt20)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int pulses0    = 0;
    int pulses20   = 0;

    always @(negedge clk) begin
        if (done0)  pulses0++;
        if (done20) pulses20++;
    end

    int         exp_cnt = 0;
    int         exp_err = 0;
    logic [3:0] exp_led0 = 4'h0;
    logic [3:0] exp_led20 = 4'h0;
    logic [7:0] fb[$];

`ifdef ETH_RX_LED_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic nib(input logic v, input logic [3:0] d, input logic e);
        @(negedge clk);
        dv = v; rxd = d; err = e;
    endtask

    // Sends preamble, SFD, fb[] low nibble first, optional dribble, then one dv=0 cycle.
    // Returns 1 ns after the edge that sampled dv=0.
    task automatic send(input int npre, input bit dribble, input int err_at);
        logic [7:0] b;
        for (int i = 0; i < npre; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < fb.size(); i++) begin
            b = fb[i];
            nib(1'b1, b[3:0], i == err_at);
            nib(1'b1, b[7:4], i == err_at);
        end
        if (dribble) nib(1'b1, 4'h9, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic build(input int n, input logic [7:0] b0);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(i == 0 ? b0 : (b0 ^ 8'((i * 7 + 3) & 255)));
    endtask

    task automatic check_frame(input string tag, input int exp_len);
        chk($sformatf("%s.done", tag),   done0, 1);
        chk($sformatf("%s.len0", tag),   len0,  exp_len);
        chk($sformatf("%s.cnt0", tag),   cnt0,  exp_cnt);
        chk($sformatf("%s.led0", tag),   led0,  exp_led0);
        chk($sformatf("%s.ecnt0", tag),  ecnt0, exp_err);
        chk($sformatf("%s.len20", tag),  len20, exp_len);
        chk($sformatf("%s.cnt20", tag),  cnt20, exp_cnt);
        chk($sformatf("%s.led20", tag),  led20, exp_led20);
        chk($sformatf("%s.ecnt20", tag), ecnt20, exp_err);
        chk($sformatf("%s.act", tag),    act0,  1);
    endtask

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        bit         dribble;
        int         err_at;
        int         exp_len;
        logic [3:0] exp_led0;
        logic [3:0] exp_led20;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int p0, n, eat, nb;
        bit bad, drb;

        tbl[0] = '{64,   8'hA7, 1'b0, -1, 64,   4'h7, 4'h8};
        tbl[1] = '{10,   8'h31, 1'b0, -1, 10,   4'h1, 4'h8};
        tbl[2] = '{5,    8'h6E, 1'b1, -1, 5,    4'hE, 4'h8};
        tbl[3] = '{30,   8'h5C, 1'b0, 12, 30,   ERR_EN ? 4'hE : 4'hC, ERR_EN ? 4'h8 : 4'h3};
        tbl[4] = '{21,   8'h42, 1'b0, -1, 21,   4'h2, 4'hD};
        tbl[5] = '{20,   8'h10, 1'b0, -1, 20,   4'h0, 4'hD};
        tbl[6] = '{2050, 8'h99, 1'b0, -1, 2047, 4'h9, 4'h6};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.led",  led0, 0);
        chk("rst.act",  act0, 0);
        chk("rst.done", done0, 0);
        chk("rst.len",  len0, 0);
        chk("rst.cnt",  cnt0, 0);
        chk("rst.ecnt", ecnt0, 0);

        foreach (tbl[i]) begin
            build(tbl[i].nbytes, tbl[i].b0);
            send(15, tbl[i].dribble, tbl[i].err_at);
            exp_cnt++;
            if (ERR_EN && tbl[i].err_at >= 0) exp_err++;
            exp_led0  = tbl[i].exp_led0;
            exp_led20 = tbl[i].exp_led20;
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_len);
        end

        n = 0;
        while (act0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("act_len", n, HOLD);
        chk("done_pulses", pulses0, 7);
        chk("done_pulses20", pulses20, 7);

        // Bad nibble inside the preamble: drop into WAIT until dv falls.
        p0 = pulses0;
        for (int i = 0; i < 4; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'h3, 1'b0);
        nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 6; i++) nib(1'b1, 4'hA, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
        repeat (3) nib(1'b0, 4'h0, 1'b0);
        chk("badpre.pulses", pulses0, p0);
        chk("badpre.cnt", cnt0, exp_cnt);
        build(8, 8'h3B);
        send(7, 1'b0, -1);
        exp_cnt++;
        exp_led0 = 4'hB;
        check_frame("afterbad", 8);

        // Reset in the middle of DATA while dv stays high.
        build(10, 8'h77);
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 10; i++) nib(1'b1, 4'(i), 1'b0);
        @(negedge clk); rst = 1'b1; rxd = 4'h5;
        @(negedge clk); rst = 1'b0;
        p0 = pulses0;
        for (int i = 0; i < 30; i++) nib(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        repeat (3) nib(1'b0, 4'h0, 1'b0);
        chk("midrst.pulses", pulses0, p0);
        chk("midrst.cnt", cnt0, 0);
        chk("midrst.len", len0, 0);
        chk("midrst.led", led0, 0);
        chk("midrst.ecnt", ecnt0, 0);
        chk("midrst.cnt20", cnt20, 0);
        exp_cnt = 0; exp_err = 0; exp_led0 = 4'h0; exp_led20 = 4'h0;
        build(25, 8'h6B);
        send(15, 1'b0, -1);
        exp_cnt++;
        exp_led0 = 4'hB;
        exp_led20 = 4'h4;
        check_frame("postrst", 25);

        // Randomized back-to-back frames against a byte-list model.
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(0, 60);
            fb.delete();
            for (int i = 0; i < nb; i++) fb.push_back(8'($urandom_range(0, 255)));
            drb = 1'($urandom_range(0, 1));
            eat = ($urandom_range(0, 3) == 0 && nb > 0) ? $urandom_range(0, nb - 1) : -1;
            send($urandom_range(1, 15), drb, eat);
            bad = ERR_EN && (eat >= 0);
            exp_cnt++;
            if (bad) exp_err++;
            if (!bad && nb > 0)    exp_led0  = fb[0][3:0];
            if (!bad && nb > OFF2) exp_led20 = fb[OFF2][3:0];
            check_frame($sformatf("rnd%0d", f), nb > 2047 ? 2047 : nb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
